// File: rtl/seg7_scan_display_pkg.sv
// rtl/seg7_scan_display_pkg.sv - shared types, segment table and encoder for seg7_scan_display
package seg7_pkg;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} glyphs for nibble values 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    return SEG_LUT[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// rtl/seg7_scan_display_if.sv - load/display bundle between a lab block and seg7_scan_display
interface seg7_scan_display_if #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 16
);
  logic              load;
  logic [BIN_W-1:0]  value;
  logic              mode_dec;
  logic              blank_lz;
  logic              busy;
  logic [DIGITS-1:0] an;
  logic [6:0]        seg;

  modport master (output load, value, mode_dec, blank_lz, input busy, an, seg);
  modport slave  (input load, value, mode_dec, blank_lz, output busy, an, seg);
endinterface

// File: rtl/seg7_scan_display_bin2bcd.sv
// rtl/seg7_scan_display_bin2bcd.sv - sequential double-dabble, one shift-add-3 step per clock
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      value,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  import seg7_pkg::*;

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_r;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] iter;
  logic             run;

  always_comb begin
    bcd_adj = bcd_r;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
    end
  end

  // bcd is the result of the step taken at the coming edge, so the owner can
  // capture the final value on the same edge that done is seen
  assign bcd  = {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
  assign done = run && (iter == CNT_W'(BIN_W - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bin_sr <= '0;
      bcd_r  <= '0;
      iter   <= '0;
      run    <= 1'b0;
    end else if (start) begin
      bin_sr <= value;
      bcd_r  <= '0;
      iter   <= '0;
      run    <= 1'b1;
    end else if (run) begin
      bcd_r  <= bcd;
      bin_sr <= bin_sr << 1;
      iter   <= iter + CNT_W'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - multiplexed common-anode 7-segment driver with hex/decimal rendering
module seg7_scan_display #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 16,
  parameter int DIV    = 100000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  seg7_scan_display_if.slave   dbus
);
  import seg7_pkg::*;

  localparam int    DISP_W  = 4 * DIGITS;
  localparam int    DIV_W   = $clog2(DIV);
  localparam int    IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam longint MAX_BIN = (longint'(1) << BIN_W) - 1;
  localparam longint DEC_CAP = longint'(10) ** DIGITS;

  if (DIGITS < 1 || DIGITS > 8 || DIV < 2 || 4*DIGITS < BIN_W || DEC_CAP <= MAX_BIN) begin : g_param_check
    $error("seg7_scan_display: DIGITS/BIN_W/DIV combination cannot be displayed");
  end

  state_t              state;
  logic [BIN_W-1:0]    value_l;
  logic                mode_l;
  logic                blank_l;
  logic [DISP_W-1:0]   disp;
  logic [DIV_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    digit_idx;
  logic [DIGITS-1:0]   an_r;
  logic [6:0]          seg_r;
  logic                bcd_done;
  logic [DISP_W-1:0]   bcd_out;
  logic                conv_done;
  logic                accept;
  logic [3:0]          nib;
  logic                blank_d;

  // A load on the finishing edge of a conversion is taken, not dropped
  assign conv_done = (state == CONV) && (!mode_l || bcd_done);
  assign accept    = dbus.load && ((state == IDLE) || conv_done);

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_bcd (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (accept && dbus.mode_dec),
    .value   (dbus.value),
    .done    (bcd_done),
    .bcd     (bcd_out)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      value_l <= '0;
      mode_l  <= 1'b0;
      blank_l <= 1'b0;
      disp    <= '0;
    end else begin
      if (conv_done) begin
        disp  <= mode_l ? bcd_out : DISP_W'(value_l);
        state <= IDLE;
      end
      if (accept) begin
        value_l <= dbus.value;
        mode_l  <= dbus.mode_dec;
        blank_l <= dbus.blank_lz;
        state   <= CONV;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      digit_idx <= '0;
    end else if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt   <= '0;
      digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  // Digit i is a leading zero when every nibble from i upwards is zero
  always_comb begin
    nib     = disp[{digit_idx, 2'b00} +: 4];
    blank_d = blank_l && (digit_idx != '0) && ((disp >> {digit_idx, 2'b00}) == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      an_r  <= '1;
      seg_r <= SEG_BLANK;
    end else begin
      an_r  <= blank_d ? '1 : ~(DIGITS'(1) << digit_idx);
      seg_r <= blank_d ? SEG_BLANK : seg7_encode(nib);
    end
  end

  assign dbus.busy = (state == CONV);
  assign dbus.an   = an_r;
  assign dbus.seg  = seg_r;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb/tb_seg7_scan_display.sv - scoreboard bench for seg7_scan_display
module tb_seg7_scan_display;
  localparam int DIGITS = 8;
  localparam int BIN_W  = 16;
  localparam int DIV    = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  seg7_scan_display_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dbus ();

  seg7_scan_display #(.DIGITS(DIGITS), .BIN_W(BIN_W), .DIV(DIV)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .dbus    (dbus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [55:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'h0: ref_seg = 7'b1000000;  4'h1: ref_seg = 7'b1111001;
      4'h2: ref_seg = 7'b0100100;  4'h3: ref_seg = 7'b0110000;
      4'h4: ref_seg = 7'b0011001;  4'h5: ref_seg = 7'b0010010;
      4'h6: ref_seg = 7'b0000010;  4'h7: ref_seg = 7'b1111000;
      4'h8: ref_seg = 7'b0000000;  4'h9: ref_seg = 7'b0010000;
      4'hA: ref_seg = 7'b0001000;  4'hB: ref_seg = 7'b0000011;
      4'hC: ref_seg = 7'b1000110;  4'hD: ref_seg = 7'b0100001;
      4'hE: ref_seg = 7'b0000110;  default: ref_seg = 7'b0001110;
    endcase
  endfunction

  // Expected glyph per digit, 7'h7f for a blanked digit
  function automatic logic [55:0] model(input logic [15:0] v, input bit dec, input bit blz);
    logic [3:0]  nib [8];
    logic [55:0] r;
    bit          lead;
    int          x;
    x = int'(v);
    for (int i = 0; i < 8; i++) begin
      nib[i] = 4'(dec ? x % 10 : x % 16);
      x      = dec ? x / 10 : x / 16;
    end
    lead = 1'b1;
    r    = '0;
    for (int i = 7; i >= 0; i--) begin
      if (nib[i] != 4'd0) lead = 1'b0;
      r[7*i +: 7] = (blz && lead && i > 0) ? 7'h7f : ref_seg(nib[i]);
    end
    return r;
  endfunction

  task automatic do_load(input logic [15:0] v, input bit dec, input bit blz, input bit push);
    dbus.load     = 1'b1;
    dbus.value    = v;
    dbus.mode_dec = dec;
    dbus.blank_lz = blz;
    if (push) exp_q.push_back(model(v, dec, blz));
    @(negedge clock);
    dbus.load     = 1'b0;
    dbus.mode_dec = ~dec;
    dbus.blank_lz = ~blz;
  endtask

  // kind 1 pulses load, kind 2 pulses reset_n low, at busy cycle inj_at
  task automatic run_busy(input int inj_at, input int kind, input logic [15:0] v,
                          input bit dec, input bit blz, output int n);
    n = 0;
    while (dbus.busy === 1'b1 && n < 200) begin
      n++;
      if (n == inj_at && kind == 1) begin
        dbus.load = 1'b1; dbus.value = v; dbus.mode_dec = dec; dbus.blank_lz = blz;
      end
      if (n == inj_at && kind == 2) reset_n = 1'b0;
      @(negedge clock);
      dbus.load = 1'b0;
      reset_n   = 1'b1;
    end
  endtask

  task automatic check_display(input string tag);
    logic [55:0] exp;
    logic [55:0] got;
    int          lit [8];
    int          blank_n;
    int          exp_blank;
    int          bad_n;
    int          idx;
    if (exp_q.size() == 0) begin
      chk({tag, " queue_empty"}, 64'd0, 64'd1);
      return;
    end
    exp       = exp_q.pop_front();
    got       = '1;
    blank_n   = 0;
    exp_blank = 0;
    bad_n     = 0;
    for (int i = 0; i < 8; i++) lit[i] = 0;
    @(negedge clock);
    for (int c = 0; c < DIGITS*DIV; c++) begin
      if (dbus.an == 8'hff) begin
        blank_n++;
        if (dbus.seg !== 7'h7f) bad_n++;
      end else begin
        idx = -1;
        for (int i = 0; i < 8; i++) if (dbus.an == ~(8'(1) << i)) idx = i;
        if (idx < 0) bad_n++;
        else begin
          if (lit[idx] > 0 && got[7*idx +: 7] !== dbus.seg) bad_n++;
          got[7*idx +: 7] = dbus.seg;
          lit[idx]++;
        end
      end
      @(negedge clock);
    end
    chk({tag, " segs"}, got, exp);
    for (int i = 0; i < 8; i++) begin
      if (exp[7*i +: 7] == 7'h7f) begin
        exp_blank += DIV;
        chk($sformatf("%s lit%0d", tag, i), lit[i], 0);
      end else begin
        chk($sformatf("%s lit%0d", tag, i), lit[i], DIV);
      end
    end
    chk({tag, " blank_cycles"}, blank_n, exp_blank);
    chk({tag, " bad_samples"}, bad_n, 0);
  endtask

  initial begin
    int n;
    dbus.load = 1'b0; dbus.value = '0; dbus.mode_dec = 1'b0; dbus.blank_lz = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset an", dbus.an, 8'hff);
    chk("reset seg", dbus.seg, 7'h7f);
    chk("reset busy", dbus.busy, 1'b0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("release an", dbus.an, 8'hfe);
    chk("release seg", dbus.seg, 7'b1000000);

    do_load(16'd31521, 1'b0, 1'b0, 1'b1);
    run_busy(0, 0, 16'd0, 1'b0, 1'b0, n);
    chk("hex busy_len", n, 1);
    check_display("hex");

    do_load(16'd31521, 1'b1, 1'b1, 1'b1);
    run_busy(0, 0, 16'd0, 1'b0, 1'b0, n);
    chk("dec busy_len", n, 16);
    check_display("dec_blank");

    do_load(16'hFFFF, 1'b1, 1'b1, 1'b1);
    run_busy(5, 1, 16'd0, 1'b1, 1'b0, n);
    chk("drop busy_len", n, 16);
    check_display("drop");

    do_load(16'h00AB, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(model(16'h1234, 1'b0, 1'b1));
    run_busy(1, 1, 16'h1234, 1'b0, 1'b1, n);
    chk("chain busy_len", n, 2);
    check_display("chain");

    do_load(16'd4660, 1'b1, 1'b0, 1'b0);
    run_busy(8, 2, 16'd0, 1'b0, 1'b0, n);
    chk("abort busy_len", n, 8);
    chk("abort busy", dbus.busy, 1'b0);
    chk("abort an", dbus.an, 8'hff);
    chk("abort seg", dbus.seg, 7'h7f);
    exp_q.push_back(model(16'd0, 1'b0, 1'b0));
    check_display("abort");

    do_load(16'd0, 1'b1, 1'b1, 1'b1);
    run_busy(0, 0, 16'd0, 1'b0, 1'b0, n);
    chk("zero busy_len", n, 16);
    check_display("zero_blank");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
